// File: rtl/camera_tile_packer.sv
// camera_tile_packer
//   Converts a captured RGB565 byte stream into 8x8 tiles of 32-bit
//   {8'h00,R8,G8,B8} pixels. One 8-line strip is assembled in the write
//   bank of a double-banked RAM. The other bank is read out as 256-bit
//   tile rows over a valid/ready handshake.
//
// Ports
//   clk, reset_n          sole clock; synchronous active-low reset
//   in_valid, in_data     one RGB565 byte per valid cycle, high byte first
//   in_sof, in_sol        start of frame / line, flag the first byte
//   out_valid, out_ready  row handshake; out_* are held while stalled
//   out_row               8 pixels, pixel 0 (leftmost) in [31:0]
//   out_row_idx           row inside the tile (0..7)
//   out_tile_x/out_tile_y tile column / strip index
//   out_last              final row of the final tile of the frame
//   overflow              sticky flag: a completed strip was dropped
module camera_tile_packer #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int TX_W       = 6,
    parameter int TY_W       = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    input  logic            in_sof,
    input  logic            in_sol,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [255:0]    out_row,
    output logic [2:0]      out_row_idx,
    output logic [TX_W-1:0] out_tile_x,
    output logic [TY_W-1:0] out_tile_y,
    output logic            out_last,
    output logic            overflow
);

    localparam int XW    = $clog2(IMG_WIDTH + 1);
    localparam int SYW   = TY_W + 1;
    localparam int AW    = 1 + 3 + TX_W;
    localparam int DEPTH = 1 << AW;

    localparam logic [XW-1:0]   X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [SYW-1:0]  STRIPS  = SYW'(IMG_HEIGHT / 8);
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(IMG_WIDTH / 8 - 1);
    localparam logic [TY_W-1:0] TY_LAST = TY_W'(IMG_HEIGHT / 8 - 1);

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_FETCH   = 2'd1,
        RD_PRESENT = 2'd2
    } rd_state_t;

    // RGB565 -> RGB888 by replicating the high bits into the low bits
    function automatic logic [31:0] expand(input logic [7:0] hi, input logic [7:0] lo);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = hi[7:3];
        g6 = {hi[2:0], lo[7:5]};
        b5 = lo[4:0];
        return {8'h00, r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    // ------------------------------------------------------------------
    // Strip RAM: address {bank, line-in-strip, tile column}
    // ------------------------------------------------------------------
    logic [255:0]  mem [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [255:0]  wr_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Write side state
    // ------------------------------------------------------------------
    logic            phase;
    logic [7:0]      hi_byte;
    logic [223:0]    pix_sr;       // seven most recent pixels of the group
    logic [XW-1:0]   x;
    logic [2:0]      line;
    logic [SYW-1:0]  strip_y;
    logic            line_active;
    logic            done_p1;
    logic            done_p2;
    logic [TY_W-1:0] done_y;
    logic            wbank;
    logic            rbank;
    logic [TY_W-1:0] rd_y;

    // Decoded view of the current byte with sof/sol restarts applied
    logic            start;
    logic            accept;
    logic            phase_eff;
    logic [XW-1:0]   x_eff;
    logic [2:0]      line_eff;
    logic [SYW-1:0]  strip_eff;
    logic            pixel_done;
    logic            word_done;
    logic            line_end;
    logic [255:0]    word;
    logic [TX_W-1:0] tile_x_w;

    always_comb begin
        start      = in_valid && (in_sof || (in_sol && (strip_y != STRIPS)));
        accept     = start || (in_valid && line_active);
        phase_eff  = start ? 1'b0 : phase;
        x_eff      = start ? '0 : x;
        line_eff   = in_sof ? 3'd0 : line;
        strip_eff  = in_sof ? '0 : strip_y;
        pixel_done = accept && phase_eff;
        word_done  = pixel_done && (x_eff[2:0] == 3'd7);
        line_end   = pixel_done && (x_eff == X_LAST);
        word       = {expand(hi_byte, in_data), pix_sr};
        tile_x_w   = TX_W'(x_eff >> 3);
    end

    // ------------------------------------------------------------------
    // Read side control
    // ------------------------------------------------------------------
    rd_state_t       state;
    rd_state_t       state_next;
    logic            last_xfer;
    logic            rd_free;
    logic            handoff;
    logic            rd_load;
    logic [2:0]      n_row;
    logic [TX_W-1:0] n_tx;
    logic [AW-1:0]   rd_addr;

    // A strip completing in the same cycle as the final transfer takes
    // the bank that transfer frees.
    always_comb begin
        last_xfer = (state == RD_PRESENT) && out_ready &&
                    (out_row_idx == 3'd7) && (out_tile_x == TX_LAST);
        rd_free   = (state == RD_IDLE) || last_xfer;
        handoff   = done_p2 && rd_free;
    end

    always_comb begin
        state_next = state;
        rd_load    = 1'b0;
        n_row      = '0;
        n_tx       = '0;
        case (state)
            RD_IDLE: begin
                if (handoff) begin
                    state_next = RD_FETCH;
                end
            end
            RD_FETCH: begin
                rd_load    = 1'b1;
                state_next = RD_PRESENT;
            end
            RD_PRESENT: begin
                if (out_ready) begin
                    if (last_xfer) begin
                        state_next = handoff ? RD_FETCH : RD_IDLE;
                    end else begin
                        // Prefetch the next row so an accepted row is
                        // replaced on the same edge.
                        rd_load = 1'b1;
                        n_row   = out_row_idx + 3'd1;
                        n_tx    = (out_row_idx == 3'd7) ? out_tile_x + TX_W'(1) : out_tile_x;
                    end
                end
            end
            default: state_next = RD_IDLE;
        endcase
        rd_addr = {rbank, n_row, n_tx};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Write side sequencing, bank hand-over and overflow
    // ------------------------------------------------------------------
    // The hand-over is decided two cycles after the strip's final byte,
    // once the final word is in RAM. The next strip cannot produce a RAM
    // write that early (a word needs 16 bytes), so flipping wbank late
    // never splits a strip across banks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase       <= 1'b0;
            hi_byte     <= '0;
            pix_sr      <= '0;
            x           <= '0;
            line        <= '0;
            strip_y     <= '0;
            line_active <= 1'b1;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            done_p1     <= 1'b0;
            done_p2     <= 1'b0;
            done_y      <= '0;
            wbank       <= 1'b0;
            rbank       <= 1'b0;
            rd_y        <= '0;
            overflow    <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            done_p1 <= 1'b0;
            done_p2 <= done_p1;

            if (accept) begin
                line        <= line_eff;
                strip_y     <= strip_eff;
                line_active <= 1'b1;
                if (!phase_eff) begin
                    phase   <= 1'b1;
                    hi_byte <= in_data;
                    x       <= x_eff;
                end else begin
                    phase  <= 1'b0;
                    pix_sr <= word[255:32];
                    if (word_done) begin
                        wr_en   <= 1'b1;
                        wr_addr <= {wbank, line_eff, tile_x_w};
                        wr_data <= word;
                    end
                    if (line_end) begin
                        x           <= '0;
                        line_active <= 1'b0;
                        line        <= line_eff + 3'd1;
                        if (line_eff == 3'd7) begin
                            strip_y <= strip_eff + SYW'(1);
                            done_y  <= TY_W'(strip_eff);
                            done_p1 <= 1'b1;
                        end
                    end else begin
                        x <= x_eff + XW'(1);
                    end
                end
            end

            if (handoff) begin
                rbank <= wbank;
                wbank <= ~wbank;
                rd_y  <= done_y;
            end else if (done_p2) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers (RAM read data lands directly in out_row)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_row_idx <= '0;
            out_tile_x  <= '0;
            out_tile_y  <= '0;
            out_last    <= 1'b0;
        end else begin
            if (rd_load) begin
                out_valid   <= 1'b1;
                out_row     <= mem[rd_addr];
                out_row_idx <= n_row;
                out_tile_x  <= n_tx;
                out_tile_y  <= rd_y;
                out_last    <= (rd_y == TY_LAST) && (n_tx == TX_LAST) && (n_row == 3'd7);
            end else if (last_xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
